// File: rtl/dm_pkg.sv
// Shared definitions for the sized data memory: access size encodings,
// controller states and a constant log2 helper for the word-index width.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dm_state_t;

    function automatic int log2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for sized accesses: merges store data into the old word,
// extracts and extends load data, and flags misaligned half/word accesses.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    output logic [31:0] load,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = old_word[{lane, 3'b000} +: 8];
    assign half_sel = old_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        merged   = old_word;
        load     = '0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                load = {{24{sign & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                load     = {{16{sign & half_sel[15]}}, half_sel};
                misalign = lane[0];
            end
            SZ_WORD: begin
                merged   = wdata;
                load     = old_word;
                misalign = |lane;
            end
            default: begin
                merged = old_word;
                load   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// Byte-addressed data memory with sized loads/stores, error detection,
// valid/ready handshake with configurable latency and post-reset clear.
//
// state | meaning
// CLEAR | zeroing one word per cycle after reset, no requests accepted
// IDLE  | ready for a request; stores commit on the accept edge
// WAIT  | counting out the remaining read latency
// RESP  | response held until rsp_ready
module dm_sized
    import dm_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter bit          LOG_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clr_busy
);

    localparam int          AW        = log2_depth(DEPTH);
    localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
    localparam logic [15:0] WAIT_INIT = (LATENCY > 1) ? 16'(LATENCY - 2) : 16'd0;

    dm_state_t     state, state_next;
    logic [AW-1:0] clr_cnt;
    logic [15:0]   wait_cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [31:0]   old_word, merged, load;
    logic          misalign, range_err, err, accept;

    assign off       = req_addr - BASE;
    assign idx       = off[AW+1:2];
    assign range_err = {1'b0, off} >= LIMIT;
    assign old_word  = mem[idx];
    assign err       = range_err | misalign | (req_size == 2'd3);
    assign accept    = req_valid & (state == IDLE);

    dm_lane_align u_lane (
        .size     (req_size),
        .sign     (req_sign),
        .lane     (req_addr[1:0]),
        .wdata    (req_wdata),
        .old_word (old_word),
        .merged   (merged),
        .load     (load),
        .misalign (misalign)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        clr_busy   = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = idx;
        mem_wdata  = merged;
        case (state)
            CLEAR: begin
                clr_busy  = 1'b1;
                mem_we    = 1'b1;
                mem_idx   = clr_cnt;
                mem_wdata = '0;
                if (clr_cnt == AW'(DEPTH - 1)) state_next = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (LATENCY > 1) ? WAIT : RESP;
                    mem_we     = req_we & ~err;
                end
            end
            WAIT: begin
                if (wait_cnt == 16'd0) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
            if (accept) begin
                wait_cnt <= WAIT_INIT;
                rdata_q  <= (req_we | err) ? 32'd0 : load;
                err_q    <= err;
            end else if (state == WAIT && wait_cnt != 16'd0) begin
                wait_cnt <= wait_cnt - 16'd1;
            end
        end
    end

    // Storage is not reset; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (reset && mem_we) mem[mem_idx] <= mem_wdata;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (LOG_EN && reset && state == IDLE && mem_we)
            $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized: vector table plus scoreboard queue,
// with hand sequences for the clear length and reset during WAIT/CLEAR.
module tb_dm_sized;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic [31:0] req_pc = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clr_busy;

    dm_sized #(
        .DEPTH   (4096),
        .LATENCY (LAT),
        .BASE    (32'h0000_0000),
        .LOG_EN  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_pc    (req_pc),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .clr_busy  (clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
        v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Counts clr_busy cycles starting at the current negedge.
    task automatic wait_clear(output int n, output int bad);
        n = 0;
        bad = 0;
        while (clr_busy && n < 5000) begin
            if (req_ready) bad++;
            n++;
            @(negedge clk);
        end
    endtask

    // Entered and left at a negedge.
    task automatic do_req(input vec_t v, input string tag);
        int          lat;
        int          unstable;
        int          busy_ready;
        logic [31:0] held_d;
        logic        held_e;
        exp_t        e;
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_sign  = v.sign;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_pc    = 32'h0000_0100 + v.addr;
        check($sformatf("%s ready", tag), {31'd0, req_ready}, 32'd1);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        busy_ready = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_ready++;
        end while (!rsp_valid && lat < 20);
        check($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
        check($sformatf("%s ready low", tag), 32'(busy_ready), 32'd0);
        held_d = rsp_rdata;
        held_e = rsp_err;
        unstable = 0;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== held_d || rsp_err !== held_e || req_ready) unstable++;
        end
        if (v.hold > 0) check($sformatf("%s hold", tag), 32'(unstable), 32'd0);
        rsp_ready = 1'b1;
        e = sb.pop_front();
        check($sformatf("%s rdata", tag), rsp_rdata, e.rdata);
        check($sformatf("%s err", tag), {31'd0, rsp_err}, {31'd0, e.err});
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s drop", tag), {rsp_valid, rsp_err, req_ready}, 32'b001);
        check($sformatf("%s rdata zero", tag), rsp_rdata, 32'd0);
    endtask

    initial begin
        int   n, bad, saw;
        vec_t v;

        add(0, 2, 0, 32'h40,       32'h0,         0, 32'h0000_0000, 0);
        add(1, 2, 0, 32'h10,       32'h8000_FF7F, 0, 32'h0000_0000, 0);
        add(0, 0, 1, 32'h10,       32'h0,         0, 32'h0000_007F, 0);
        add(0, 0, 1, 32'h11,       32'h0,         0, 32'hFFFF_FFFF, 0);
        add(0, 0, 0, 32'h11,       32'h0,         0, 32'h0000_00FF, 0);
        add(0, 0, 1, 32'h13,       32'h0,         0, 32'hFFFF_FF80, 0);
        add(0, 1, 0, 32'h12,       32'h0,         0, 32'h0000_8000, 0);
        add(0, 1, 1, 32'h12,       32'h0,         0, 32'hFFFF_8000, 0);
        add(0, 1, 1, 32'h10,       32'h0,         0, 32'hFFFF_FF7F, 0);
        add(0, 2, 1, 32'h10,       32'h0,         0, 32'h8000_FF7F, 0);
        add(1, 2, 0, 32'h20,       32'h1122_3344, 0, 32'h0000_0000, 0);
        add(1, 0, 0, 32'h21,       32'hFFFF_FFAB, 0, 32'h0000_0000, 0);
        add(0, 2, 0, 32'h20,       32'h0,         0, 32'h1122_AB44, 0);
        add(1, 1, 0, 32'h22,       32'h1234_BEEF, 0, 32'h0000_0000, 0);
        add(0, 2, 0, 32'h20,       32'h0,         0, 32'hBEEF_AB44, 0);
        add(1, 2, 0, 32'h00,       32'h1234_5678, 0, 32'h0000_0000, 0);
        add(1, 1, 0, 32'h03,       32'h0000_FFFF, 0, 32'h0000_0000, 1);
        add(0, 2, 0, 32'h00,       32'h0,         0, 32'h1234_5678, 0);
        add(0, 2, 0, 32'h4000,     32'h0,         0, 32'h0000_0000, 1);
        add(0, 3, 0, 32'h10,       32'h0,         0, 32'h0000_0000, 1);
        add(0, 2, 0, 32'h12,       32'h0,         0, 32'h0000_0000, 1);
        add(0, 1, 1, 32'h13,       32'h0,         0, 32'h0000_0000, 1);
        add(0, 2, 0, 32'h3FFC,     32'h0,         0, 32'h0000_0000, 0);
        add(1, 2, 0, 32'h3FFC,     32'hDEAD_BEEF, 0, 32'h0000_0000, 0);
        add(1, 2, 0, 32'hFFFF_FFFC, 32'h0,        0, 32'h0000_0000, 1);
        add(0, 2, 0, 32'h3FFC,     32'h0,         5, 32'hDEAD_BEEF, 0);
        add(0, 0, 0, 32'h4000,     32'h0,         0, 32'h0000_0000, 1);
        add(1, 0, 0, 32'h4001,     32'h0000_005A, 0, 32'h0000_0000, 1);
        add(0, 2, 0, 32'h00,       32'h0,         0, 32'h1234_5678, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {27'd0, req_ready, rsp_valid, rsp_err, clr_busy, 1'b0}, 32'b00010);
        check("reset rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        wait_clear(n, bad);
        check("clear length", 32'(n), 32'd4096);
        check("clear ready low", 32'(bad), 32'd0);
        check("ready after clear", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_req(v, $sformatf("v%0d", i));
        end

        // Store accepted, then reset while its response is still in WAIT.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_sign = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h55; req_pc = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) saw++;
        end
        check("reset in wait clr_busy", {31'd0, clr_busy}, 32'd1);
        reset = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid) saw++;
        end
        check("no rsp after reset", 32'(saw), 32'd0);
        // Reset again mid-clear; the clear must restart from word 0.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_clear(n, bad);
        check("restarted clear length", 32'(n), 32'd4096);
        check("restarted clear ready low", 32'(bad), 32'd0);
        v.we = 1'b0; v.size = 2'd2; v.sign = 1'b0; v.addr = 32'h8; v.wdata = 32'h0;
        v.hold = 0; v.exp_rdata = 32'h0; v.exp_err = 1'b0;
        do_req(v, "lw after reset");
        v.addr = 32'h20;
        do_req(v, "lw 20 after reset");
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
- Parametrised data memory for the multi-cycle and pipelined CPU datapaths; successor to the word-only single-cycle DM.
- Adds byte-addressed byte, half and word access with sign or zero extension.
- Adds alignment and range error detection, a valid/ready request/response handshake with configurable read latency, and a sequential post-reset clear.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of 2.
- LATENCY, 1, cycles from request accept to rsp_valid; must be ≥1.
- BASE, 32'h0000_0000, byte address mapped to word 0; 4-byte aligned.
- LOG_EN, 1, simulation-only store log on/off.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_sign  in  1  load extension: 1 = sign, 0 = zero.
- req_pc  in  32  PC of the issuing instruction; used for logging only.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or used size 3.
- clr_busy  out  1  post-reset clear in progress.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state←CLEAR, clear counter←0, wait counter←0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_busy=1.
- FSM states: CLEAR, IDLE, WAIT, RESP. Only one request is outstanding at a time.
- CLEAR:
  - Writes 0 to word[clr_cnt] each cycle and increments clr_cnt.
  - After writing DEPTH-1, moves to IDLE; the clear takes exactly DEPTH cycles.
  - req_ready=0 and clr_busy=1 throughout.
- IDLE:
  - req_ready=1 and clr_busy=0.
  - An accept is req_valid & req_ready at a rising edge. On accept:
    - Capture the request.
    - Compute the error.
    - Commit the store on that same edge if there is no error.
    - Capture the load data from the pre-store memory contents.
  - Next state: WAIT if LATENCY>1, otherwise RESP.
- WAIT: counts LATENCY-1 cycles, then moves to RESP. req_ready=0.
- RESP:
  - rsp_valid=1 with stable rsp_rdata and rsp_err.
  - On rsp_ready, move to IDLE; rsp_valid, rsp_rdata and rsp_err drop to 0 the next cycle.
  - If rsp_ready is held 0, the response is held indefinitely.
- Latency: rsp_valid first rises LATENCY cycles after the accept edge.
- Back-to-back: a load accepted after a store's response returns the stored value.
- Errors (any one sets rsp_err):
  - Out of range: (req_addr - BASE) ≥ DEPTH×4, unsigned.
  - Misaligned half: size=1 and addr[0]=1.
  - Misaligned word: size=2 and addr[1:0]≠0.
  - Reserved size: size=3.
  - On error: no memory write, and rsp_rdata=0.
- Word index: (req_addr - BASE)[log2(DEPTH)+1:2]. Lane select: addr[1:0].
- Stores:
  - Byte: writes lane addr[1:0] with wdata[7:0].
  - Half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - Word: writes all four lanes.
  - Unwritten lanes are preserved.
- Loads: extract the byte or half from its lane, then sign- or zero-extend to 32 bits per req_sign. Word loads ignore req_sign.
- Store log: if LOG_EN and a store commits, $display "@%h: *%h <= %h" with pc, the word-aligned byte address, and the full merged word. Nothing is logged for errored stores.
- Reset mid-operation:
  - Any pending response is dropped.
  - A store committed at its accept edge is not undone, but the restarted CLEAR wipes it.
  - reset=0 during CLEAR restarts clr_cnt at 0.
- Simultaneous events: reset=0 overrides accept, response handshake and clear.

Decomposition:
- Shared package dm_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum dm_state_t {CLEAR, IDLE, WAIT, RESP}.
  - Function for log2 of DEPTH.
- One combinational sub-module, dm_lane_align. Inputs: size, sign, addr[1:0], wdata, old word. Outputs: merged store word, extended load data, misalign flag.

Test Plan:
- Reset, release: clr_busy high for exactly 4096 cycles, req_ready=0 throughout, then req_ready=1; a load of addr 0x40 returns 0.
- sw 0x8000_FF7F @0x10; lb sign @0x10 → 0x0000_007F; lb sign @0x11 → 0xFFFF_FFFF; lhu @0x12 → 0x0000_8000; lh @0x12 → 0xFFFF_8000.
- sb 0xAB @0x21 over word 0x1122_3344 @0x20 → lw @0x20 returns 0x1122_AB44; log prints "@<pc>: *00000020 <= 1122ab44".
- sh @0x03 → rsp_err=1, rdata=0, memory unchanged; lw @0x4000 with BASE=0 → rsp_err=1; size=3 → rsp_err=1.
- LATENCY=3, rsp_ready held 0 for 5 cycles: rsp_valid rises 3 cycles after accept, data stable while held, req_ready=0 until the handshake.
- Assert reset in WAIT after sw 0x55 @0x8: rsp_valid never asserted, CLEAR restarts, later lw @0x8 → 0.
